des_key_sched_seq: RTL and testbench

Sequential DES key-schedule engine: accepts one 64-bit key and streams 48-bit round keys, one per handshake, in encrypt order (K1..Kn) or decrypt order (Kn..K1).
- Replaces the flat, 16-instance combinational subkey fan-out with a single PC-1 / shift / PC-2 datapath that is iterated over the rounds.
- Sits between the key input and the round engine; the consumer can apply backpressure.

---
 rtl/des_key_sched_seq.sv | 183 ++++++++++++++++++
 tb/tb_des_key_sched_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: one PC-1 / rotate / PC-2 datapath iterated over the rounds,
// streaming round keys in encrypt or decrypt order. Optional macro: DES_KS_PARITY_CHECK_EN.
module des_key_sched_seq #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [63:0]      key,
  input  logic             decrypt,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [47:0]      rk,
  output logic [IDX_W-1:0] rk_idx,
  output logic             rk_last,
  output logic             busy,
  output logic             key_err
);

  localparam int unsigned CNT_W = IDX_W + 1;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic int unsigned shift_amt(input int unsigned k);
    return (k == 1 || k == 2 || k == 9 || k == 16) ? 32'd1 : 32'd2;
  endfunction

  // Total left rotation from C0/D0 to C_ROUNDS/D_ROUNDS, reduced modulo 28.
  function automatic int unsigned shift_sum(input int unsigned n);
    int unsigned s;
    s = 0;
    for (int unsigned k = 1; k <= 16; k++) begin
      if (k <= n) s = s + shift_amt(k);
    end
    return s % 28;
  endfunction

  localparam int unsigned SHIFT_SUM = shift_sum(ROUNDS);

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input int unsigned n,
                                         input logic left);
    logic [55:0] c2, d2;
    c2 = {cd[55:28], cd[55:28]};
    d2 = {cd[27:0], cd[27:0]};
    if (left) begin
      c2 = c2 << n;
      d2 = d2 << n;
      return {c2[55:28], d2[55:28]};
    end
    c2 = c2 >> n;
    d2 = d2 >> n;
    return {c2[27:0], d2[27:0]};
  endfunction

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [55:0]      cd_q, ld_cd, adv_cd;
  logic [CNT_W-1:0] idx_q, ld_idx, adv_idx;
  logic             dec_q, adv_last;
  logic             accept_c, load_c, xfer_c, key_bad_c;

  assign accept_c = key_valid && key_ready;
  assign load_c   = accept_c && !key_bad_c;
  assign xfer_c   = rk_valid && rk_ready;
  assign rk_idx   = idx_q[IDX_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_c) state_d = GEN;
      GEN:     if (xfer_c && rk_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM status outputs; key_ready is held low while reset is applied
  always_comb begin
    key_ready = (state_q == IDLE) && !rst;
    busy      = (state_q == GEN);
  end

  // Load point (PC-1 plus initial rotation) and per-transfer advance of C/D
  always_comb begin
    ld_cd    = rot_cd(pc1(key), decrypt ? SHIFT_SUM : 32'd1, 1'b1);
    ld_idx   = decrypt ? CNT_W'(ROUNDS) : CNT_W'(1);
    adv_cd   = cd_q;
    adv_idx  = idx_q;
    adv_last = 1'b0;
    if (dec_q) begin
      adv_cd   = rot_cd(cd_q, shift_amt(32'(idx_q)), 1'b0);
      adv_idx  = idx_q - CNT_W'(1);
      adv_last = (adv_idx == CNT_W'(1));
    end else begin
      adv_cd   = rot_cd(cd_q, shift_amt(32'(idx_q) + 32'd1), 1'b1);
      adv_idx  = idx_q + CNT_W'(1);
      adv_last = (adv_idx == CNT_W'(ROUNDS));
    end
  end

  // Round-key output register; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_q     <= '0;
      idx_q    <= '0;
      dec_q    <= 1'b0;
      rk       <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
    end else if (load_c) begin
      cd_q     <= ld_cd;
      idx_q    <= ld_idx;
      dec_q    <= decrypt;
      rk       <= pc2(ld_cd);
      rk_valid <= 1'b1;
      rk_last  <= (ROUNDS == 1);
    end else if (xfer_c) begin
      if (rk_last) begin
        rk_valid <= 1'b0;
        rk_last  <= 1'b0;
      end else begin
        cd_q    <= adv_cd;
        idx_q   <= adv_idx;
        rk      <= pc2(adv_cd);
        rk_last <= adv_last;
      end
    end
  end

`ifdef DES_KS_PARITY_CHECK_EN
  // Every key byte must carry odd parity
  always_comb begin
    key_bad_c = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) key_bad_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) key_err <= 1'b0;
    else     key_err <= accept_c && key_bad_c;
  end
`else
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
  assign key_bad_c     = 1'b0;
  assign key_err       = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Directed bench for des_key_sched_seq using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_sched_seq;

  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K3  = 48'h55FC8A42CF99;
  localparam logic [47:0] K4  = 48'h72ADD6DB351D;
  localparam logic [47:0] K15 = 48'hBF918D3D3F0A;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;
  localparam logic [63:0] KEY_OK  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  logic        clk, rst, key_valid, key_valid4, rk_ready, decrypt;
  logic [63:0] key;
  logic        key_ready, rk_valid, rk_last, busy, key_err;
  logic [47:0] rk;
  logic [4:0]  rk_idx;
  logic        key_ready4, rk_valid4, rk_last4, busy4, key_err4;
  logic [47:0] rk4;
  logic [3:0]  rk_idx4;

  int checks = 0;
  int errors = 0;

  logic        sel4;
  logic        m_valid, m_last;
  logic [47:0] m_rk;
  logic [4:0]  m_idx;

  logic [47:0] got_rk   [1:16];
  logic [4:0]  got_idx  [1:16];
  logic        got_last [1:16];
  int          n_got;

  des_key_sched_seq #(.ROUNDS(16), .IDX_W(5)) u_dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .decrypt(decrypt), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
    .rk_last(rk_last), .busy(busy), .key_err(key_err));

  des_key_sched_seq #(.ROUNDS(4), .IDX_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_valid(key_valid4), .key_ready(key_ready4), .key(key),
    .decrypt(decrypt), .rk_valid(rk_valid4), .rk_ready(rk_ready), .rk(rk4), .rk_idx(rk_idx4),
    .rk_last(rk_last4), .busy(busy4), .key_err(key_err4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_valid = sel4 ? rk_valid4 : rk_valid;
    m_last  = sel4 ? rk_last4  : rk_last;
    m_rk    = sel4 ? rk4       : rk;
    m_idx   = sel4 ? {1'b0, rk_idx4} : rk_idx;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer a key at a negedge; returns at the next negedge with inputs scrambled.
  task automatic offer_key(input logic [63:0] k, input logic dec);
    key = k;
    decrypt = dec;
    if (sel4) key_valid4 = 1'b1;
    else      key_valid  = 1'b1;
    @(negedge clk);
    key_valid  = 1'b0;
    key_valid4 = 1'b0;
    key        = ~k;
    decrypt    = ~dec;
  endtask

  // Record up to max_n transfers with rk_ready high; bounded by max_n.
  task automatic drain(input int max_n);
    n_got = 0;
    while (m_valid && n_got < max_n) begin
      n_got++;
      got_rk[n_got]   = m_rk;
      got_idx[n_got]  = m_idx;
      got_last[n_got] = m_last;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_valid4 = 1'b0; rk_ready = 1'b1;
    decrypt = 1'b0; key = '0; sel4 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rk_valid", 64'(rk_valid), 64'd0);
    check("rst_rk", 64'(rk), 64'd0);
    check("rst_rk_idx", 64'(rk_idx), 64'd0);
    check("rst_rk_last", 64'(rk_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_key_err", 64'(key_err), 64'd0);
    check("rst_key_ready", 64'(key_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_key_ready", 64'(key_ready), 64'd1);

    // Encrypt order, full throughput
    offer_key(KEY_OK, 1'b0);
    check("enc_busy", 64'(busy), 64'd1);
    check("enc_key_ready_busy", 64'(key_ready), 64'd0);
    drain(16);
    check("enc_count", 64'(n_got), 64'd16);
    check("enc_k1", 64'(got_rk[1]), 64'(K1));
    check("enc_k2", 64'(got_rk[2]), 64'(K2));
    check("enc_k3", 64'(got_rk[3]), 64'(K3));
    check("enc_k4", 64'(got_rk[4]), 64'(K4));
    check("enc_k15", 64'(got_rk[15]), 64'(K15));
    check("enc_k16", 64'(got_rk[16]), 64'(K16));
    for (int j = 1; j <= 16; j++) begin
      check($sformatf("enc_idx%0d", j), 64'(got_idx[j]), 64'(j));
      check($sformatf("enc_last%0d", j), 64'(got_last[j]), 64'(j == 16));
    end
    check("enc_done_valid", 64'(rk_valid), 64'd0);
    check("enc_done_key_ready", 64'(key_ready), 64'd1);
    check("enc_done_busy", 64'(busy), 64'd0);

    // Decrypt order
    offer_key(KEY_OK, 1'b1);
    drain(16);
    check("dec_count", 64'(n_got), 64'd16);
    check("dec_p1", 64'(got_rk[1]), 64'(K16));
    check("dec_p2", 64'(got_rk[2]), 64'(K15));
    check("dec_p13", 64'(got_rk[13]), 64'(K4));
    check("dec_p16", 64'(got_rk[16]), 64'(K1));
    for (int j = 1; j <= 16; j++) begin
      check($sformatf("dec_idx%0d", j), 64'(got_idx[j]), 64'(17 - j));
      check($sformatf("dec_last%0d", j), 64'(got_last[j]), 64'(j == 16));
    end
    check("dec_done_key_ready", 64'(key_ready), 64'd1);

    // Backpressure: 3 stalled cycles at position 2
    offer_key(KEY_OK, 1'b0);
    check("bp_p1", 64'(rk), 64'(K1));
    @(negedge clk);
    rk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold_rk%0d", c), 64'(rk), 64'(K2));
      check($sformatf("bp_hold_idx%0d", c), 64'(rk_idx), 64'd2);
      check($sformatf("bp_hold_valid%0d", c), 64'(rk_valid), 64'd1);
    end
    rk_ready = 1'b1;
    @(negedge clk);
    drain(16);
    check("bp_rest_count", 64'(n_got), 64'd14);
    check("bp_p3", 64'(got_rk[1]), 64'(K3));
    check("bp_p16", 64'(got_rk[14]), 64'(K16));
    for (int j = 1; j <= 14; j++)
      check($sformatf("bp_idx%0d", j + 2), 64'(got_idx[j]), 64'(j + 2));
    check("bp_last", 64'(got_last[14]), 64'd1);

    // Abort with rst after position 5
    offer_key(KEY_OK, 1'b0);
    drain(5);
    check("abort_pre_valid", 64'(rk_valid), 64'd1);
    check("abort_pre_idx", 64'(rk_idx), 64'd6);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", 64'(rk_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_valid", 64'(rk_valid), 64'd0);
    check("abort_key_ready", 64'(key_ready), 64'd1);
    offer_key(KEY_OK, 1'b0);
    drain(16);
    check("restart_count", 64'(n_got), 64'd16);
    check("restart_k1", 64'(got_rk[1]), 64'(K1));
    check("restart_idx1", 64'(got_idx[1]), 64'd1);
    check("restart_k16", 64'(got_rk[16]), 64'(K16));

    // ROUNDS=4 instance, decrypt then encrypt
    sel4 = 1'b1;
    offer_key(KEY_OK, 1'b1);
    drain(16);
    check("r4dec_count", 64'(n_got), 64'd4);
    check("r4dec_p1", 64'(got_rk[1]), 64'(K4));
    check("r4dec_p2", 64'(got_rk[2]), 64'(K3));
    check("r4dec_p3", 64'(got_rk[3]), 64'(K2));
    check("r4dec_p4", 64'(got_rk[4]), 64'(K1));
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("r4dec_idx%0d", j), 64'(got_idx[j]), 64'(5 - j));
      check($sformatf("r4dec_last%0d", j), 64'(got_last[j]), 64'(j == 4));
    end
    offer_key(KEY_OK, 1'b0);
    drain(16);
    check("r4enc_count", 64'(n_got), 64'd4);
    check("r4enc_p1", 64'(got_rk[1]), 64'(K1));
    check("r4enc_p4", 64'(got_rk[4]), 64'(K4));
    check("r4enc_last", 64'(got_last[4]), 64'd1);
    check("r4_key_ready", 64'(key_ready4), 64'd1);
    sel4 = 1'b0;

    // Key with an even-parity byte
    offer_key(KEY_BAD, 1'b0);
`ifdef DES_KS_PARITY_CHECK_EN
    check("par_key_err", 64'(key_err), 64'd1);
    check("par_valid", 64'(rk_valid), 64'd0);
    check("par_busy", 64'(busy), 64'd0);
    check("par_key_ready", 64'(key_ready), 64'd1);
    @(negedge clk);
    check("par_key_err_pulse", 64'(key_err), 64'd0);
    check("par_still_idle", 64'(rk_valid), 64'd0);
    offer_key(KEY_OK, 1'b0);
    check("par_ok_key_err", 64'(key_err), 64'd0);
    drain(16);
    check("par_ok_count", 64'(n_got), 64'd16);
    check("par_ok_k1", 64'(got_rk[1]), 64'(K1));
`else
    check("nopar_key_err", 64'(key_err), 64'd0);
    drain(16);
    check("nopar_count", 64'(n_got), 64'd16);
    check("nopar_k1", 64'(got_rk[1]), 64'(K1));
    check("nopar_k16", 64'(got_rk[16]), 64'(K16));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
